// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  // Register-address width shared with the decode stage.
  localparam int HZ_RA_W = 5;

  typedef enum logic {
    RUN,
    MD_BUSY
  } hz_state_e;

  typedef enum logic [2:0] {
    NONE,
    LOAD_USE,
    BRANCH,
    MD_WAIT,
    MEM_WAIT
  } hz_cause_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear outranks increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use, MUL/DIV, memory-freeze and branch hazard control
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W     = HZ_RA_W,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_mem_read,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_mem_read,
  input  logic             ex_md_start,
  input  logic             md_done,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e state;
  hz_cause_e cause;
  logic      ex_hit;
  logic      mem_hit;
  logic      load_use;
  logic      md_wait;
  logic      mem_wait;

  // x0 is never a real producer, and unread operands cannot create a hazard.
  function automatic logic reads_reg(input logic [RA_W-1:0] rd,
                                     input logic [RA_W-1:0] rs1,
                                     input logic [RA_W-1:0] rs2,
                                     input logic            u1,
                                     input logic            u2);
    return (rd != '0) && ((u1 && (rs1 == rd)) || (u2 && (rs2 == rd)));
  endfunction

  assign ex_hit   = ex_mem_read && reads_reg(ex_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used);
  assign mem_hit  = (LOAD_LAT >= 2) && mem_mem_read &&
                    reads_reg(mem_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used);
  assign load_use = ex_hit || mem_hit;
  assign md_wait  = ((state == RUN) && ex_md_start && !md_done) ||
                    ((state == MD_BUSY) && !md_done);
  assign mem_wait = mem_req && !dmem_ready;

  always_comb begin
    cause = NONE;
    if (mem_wait) begin
      cause = MEM_WAIT;
    end else if (md_wait) begin
      cause = MD_WAIT;
    end else if (branch_taken) begin
      cause = BRANCH;
    end else if (load_use) begin
      cause = LOAD_USE;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    stall         = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else begin
      case (cause)
        MEM_WAIT: begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_write  = 1'b0;
          mem_wb_bubble = 1'b1;
          stall         = 1'b1;
        end
        MD_WAIT: begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          stall         = 1'b1;
        end
        BRANCH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        LOAD_USE: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          stall        = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // A freeze holds MD_BUSY, but a done pulse seen during the freeze still releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (ex_md_start && !md_done && !mem_wait) state <= MD_BUSY;
        MD_BUSY: if (md_done) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (stall),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (if_id_flush),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl at load latency 1 and 2
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic [4:0] mem_rd;
    logic       mem_mem_read;
    logic       ex_md_start;
    logic       md_done;
    logic       mem_req;
    logic       dmem_ready;
    logic       branch_taken;
    logic       cnt_clr;
  } stim_t;

  typedef struct {
    string      tag;
    logic [9:0] e1;
    logic [9:0] e2;
    int         s1;
    int         f1;
    int         s2;
    int         f2;
  } exp_t;

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
  //  ex_mem_bubble, mem_wb_bubble, if_id_flush, id_ex_flush, stall}
  localparam logic [9:0] RST  = 10'b0000_000_00_0;
  localparam logic [9:0] NORM = 10'b1111_000_00_0;
  localparam logic [9:0] LU   = 10'b0011_100_00_1;
  localparam logic [9:0] MD   = 10'b0001_010_00_1;
  localparam logic [9:0] MEMW = 10'b0000_001_00_1;
  localparam logic [9:0] BR   = 10'b1111_000_11_0;

  localparam int MAX1 = 65535;
  localparam int MAX2 = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, mem_mem_read;
  logic       ex_md_start, md_done, mem_req, dmem_ready, branch_taken, cnt_clr;

  logic        pc_write1, if_id_write1, id_ex_write1, ex_mem_write1;
  logic        id_ex_bubble1, ex_mem_bubble1, mem_wb_bubble1;
  logic        if_id_flush1, id_ex_flush1, stall1;
  logic [15:0] stall_cnt1, flush_cnt1;
  logic        pc_write2, if_id_write2, id_ex_write2, ex_mem_write2;
  logic        id_ex_bubble2, ex_mem_bubble2, mem_wb_bubble2;
  logic        if_id_flush2, id_ex_flush2, stall2;
  logic [3:0]  stall_cnt2, flush_cnt2;

  exp_t  sb[$];
  stim_t idle;
  stim_t s;
  int    n_chk  = 0;
  int    n_fail = 0;
  int    m_s1 = 0, m_f1 = 0, m_s2 = 0, m_f2 = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(5), .LOAD_LAT(1), .CNT_W(16)) u_dut1 (
    .clk (clk), .rst_n (rst_n),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2),
    .id_rs1_used (id_rs1_used), .id_rs2_used (id_rs2_used),
    .ex_rd (ex_rd), .ex_mem_read (ex_mem_read),
    .mem_rd (mem_rd), .mem_mem_read (mem_mem_read),
    .ex_md_start (ex_md_start), .md_done (md_done),
    .mem_req (mem_req), .dmem_ready (dmem_ready),
    .branch_taken (branch_taken), .cnt_clr (cnt_clr),
    .pc_write (pc_write1), .if_id_write (if_id_write1),
    .id_ex_write (id_ex_write1), .ex_mem_write (ex_mem_write1),
    .id_ex_bubble (id_ex_bubble1), .ex_mem_bubble (ex_mem_bubble1),
    .mem_wb_bubble (mem_wb_bubble1),
    .if_id_flush (if_id_flush1), .id_ex_flush (id_ex_flush1),
    .stall (stall1), .stall_cnt (stall_cnt1), .flush_cnt (flush_cnt1)
  );

  hazard_ctrl #(.RA_W(5), .LOAD_LAT(2), .CNT_W(4)) u_dut2 (
    .clk (clk), .rst_n (rst_n),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2),
    .id_rs1_used (id_rs1_used), .id_rs2_used (id_rs2_used),
    .ex_rd (ex_rd), .ex_mem_read (ex_mem_read),
    .mem_rd (mem_rd), .mem_mem_read (mem_mem_read),
    .ex_md_start (ex_md_start), .md_done (md_done),
    .mem_req (mem_req), .dmem_ready (dmem_ready),
    .branch_taken (branch_taken), .cnt_clr (cnt_clr),
    .pc_write (pc_write2), .if_id_write (if_id_write2),
    .id_ex_write (id_ex_write2), .ex_mem_write (ex_mem_write2),
    .id_ex_bubble (id_ex_bubble2), .ex_mem_bubble (ex_mem_bubble2),
    .mem_wb_bubble (mem_wb_bubble2),
    .if_id_flush (if_id_flush2), .id_ex_flush (id_ex_flush2),
    .stall (stall2), .stall_cnt (stall_cnt2), .flush_cnt (flush_cnt2)
  );

  task automatic drive(input stim_t d);
    rst_n        = d.rst_n;
    id_rs1       = d.id_rs1;
    id_rs2       = d.id_rs2;
    id_rs1_used  = d.id_rs1_used;
    id_rs2_used  = d.id_rs2_used;
    ex_rd        = d.ex_rd;
    ex_mem_read  = d.ex_mem_read;
    mem_rd       = d.mem_rd;
    mem_mem_read = d.mem_mem_read;
    ex_md_start  = d.ex_md_start;
    md_done      = d.md_done;
    mem_req      = d.mem_req;
    dmem_ready   = d.dmem_ready;
    branch_taken = d.branch_taken;
    cnt_clr      = d.cnt_clr;
  endtask

  task automatic push_exp(input string tag, input logic [9:0] e1, input logic [9:0] e2);
    exp_t x;
    x.tag = tag;
    x.e1  = e1;
    x.e2  = e2;
    x.s1  = m_s1;
    x.f1  = m_f1;
    x.s2  = m_s2;
    x.f2  = m_f2;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t       x;
    logic [9:0] o1, o2;
    n_chk++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
    end
    if (sb.size() != 0) begin
      x  = sb.pop_front();
      o1 = {pc_write1, if_id_write1, id_ex_write1, ex_mem_write1, id_ex_bubble1,
            ex_mem_bubble1, mem_wb_bubble1, if_id_flush1, id_ex_flush1, stall1};
      o2 = {pc_write2, if_id_write2, id_ex_write2, ex_mem_write2, id_ex_bubble2,
            ex_mem_bubble2, mem_wb_bubble2, if_id_flush2, id_ex_flush2, stall2};
      n_chk++;
      assert (o1 === x.e1) else begin
        n_fail++;
        $error("FAIL %s lat1 outputs: observed %b expected %b", x.tag, o1, x.e1);
      end
      n_chk++;
      assert (o2 === x.e2) else begin
        n_fail++;
        $error("FAIL %s lat2 outputs: observed %b expected %b", x.tag, o2, x.e2);
      end
      n_chk++;
      assert (stall_cnt1 === 16'(x.s1)) else begin
        n_fail++;
        $error("FAIL %s lat1 stall_cnt: observed %0d expected %0d", x.tag, stall_cnt1, x.s1);
      end
      n_chk++;
      assert (flush_cnt1 === 16'(x.f1)) else begin
        n_fail++;
        $error("FAIL %s lat1 flush_cnt: observed %0d expected %0d", x.tag, flush_cnt1, x.f1);
      end
      n_chk++;
      assert (stall_cnt2 === 4'(x.s2)) else begin
        n_fail++;
        $error("FAIL %s lat2 stall_cnt: observed %0d expected %0d", x.tag, stall_cnt2, x.s2);
      end
      n_chk++;
      assert (flush_cnt2 === 4'(x.f2)) else begin
        n_fail++;
        $error("FAIL %s lat2 flush_cnt: observed %0d expected %0d", x.tag, flush_cnt2, x.f2);
      end
    end
  endtask

  // Drive one cycle just after the edge, check at the falling edge, then
  // advance the counter model by what this cycle should have counted.
  task automatic step(input stim_t d, input string tag,
                      input logic [9:0] e1, input logic [9:0] e2);
    @(posedge clk);
    #1;
    drive(d);
    if (!d.rst_n) begin
      m_s1 = 0; m_f1 = 0; m_s2 = 0; m_f2 = 0;
    end
    push_exp(tag, e1, e2);
    @(negedge clk);
    pop_check();
    if (d.rst_n && d.cnt_clr) begin
      m_s1 = 0; m_f1 = 0; m_s2 = 0; m_f2 = 0;
    end else if (d.rst_n) begin
      if (e1[0] && m_s1 < MAX1) m_s1++;
      if (e1[2] && m_f1 < MAX1) m_f1++;
      if (e2[0] && m_s2 < MAX2) m_s2++;
      if (e2[2] && m_f2 < MAX2) m_f2++;
    end
  endtask

  initial begin
    idle = '0;
    idle.rst_n      = 1'b1;
    idle.dmem_ready = 1'b1;
    s = idle;
    s.rst_n = 1'b0;
    drive(s);

    step(s, "reset", RST, RST);
    step(idle, "idle", NORM, NORM);

    // back-to-back load -> consumer on rs2
    s = idle; s.ex_mem_read = 1'b1; s.ex_rd = 5'd5; s.id_rs2 = 5'd5; s.id_rs2_used = 1'b1;
    step(s, "lu_ex", LU, LU);
    s = idle; s.mem_mem_read = 1'b1; s.mem_rd = 5'd5; s.id_rs2 = 5'd5; s.id_rs2_used = 1'b1;
    step(s, "lu_mem", NORM, LU);
    step(idle, "lu_done", NORM, NORM);

    s = idle; s.ex_mem_read = 1'b1; s.ex_rd = 5'd0; s.id_rs2 = 5'd0; s.id_rs2_used = 1'b1;
    step(s, "lu_x0", NORM, NORM);
    s = idle; s.ex_mem_read = 1'b1; s.ex_rd = 5'd5; s.id_rs2 = 5'd5; s.id_rs1 = 5'd3;
    s.id_rs1_used = 1'b1;
    step(s, "lu_unused", NORM, NORM);

    // one independent instruction between load and consumer
    s = idle; s.mem_mem_read = 1'b1; s.mem_rd = 5'd7; s.ex_rd = 5'd2;
    s.id_rs1 = 5'd7; s.id_rs1_used = 1'b1;
    step(s, "lu_gap", NORM, LU);
    step(idle, "lu_gap_done", NORM, NORM);

    // MUL/DIV with done four cycles after start
    s = idle; s.ex_md_start = 1'b1;
    step(s, "md_issue", MD, MD);
    for (int i = 0; i < 3; i++) step(idle, "md_busy", MD, MD);
    s = idle; s.md_done = 1'b1;
    step(s, "md_done", NORM, NORM);
    step(idle, "md_after", NORM, NORM);
    s = idle; s.ex_md_start = 1'b1; s.md_done = 1'b1;
    step(s, "md_same", NORM, NORM);
    step(idle, "md_same_after", NORM, NORM);

    // freeze holds a resolved branch until the memory responds
    s = idle; s.mem_req = 1'b1; s.dmem_ready = 1'b0; s.branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) step(s, "frz_branch", MEMW, MEMW);
    s = idle; s.mem_req = 1'b1; s.branch_taken = 1'b1;
    step(s, "frz_release", BR, BR);
    step(idle, "frz_after", NORM, NORM);

    // branch wins over load-use from EX and from MEM
    s = idle; s.mem_mem_read = 1'b1; s.mem_rd = 5'd4; s.id_rs1 = 5'd4;
    s.id_rs1_used = 1'b1; s.branch_taken = 1'b1;
    step(s, "br_vs_lu_mem", BR, BR);
    s = idle; s.ex_mem_read = 1'b1; s.ex_rd = 5'd9; s.id_rs2 = 5'd9;
    s.id_rs2_used = 1'b1; s.branch_taken = 1'b1;
    step(s, "br_vs_lu_ex", BR, BR);

    // md_done arriving during a freeze in MD_BUSY
    s = idle; s.ex_md_start = 1'b1;
    step(s, "mdf_issue", MD, MD);
    s = idle; s.mem_req = 1'b1; s.dmem_ready = 1'b0;
    step(s, "mdf_frz", MEMW, MEMW);
    s.md_done = 1'b1;
    step(s, "mdf_frz_done", MEMW, MEMW);
    step(idle, "mdf_after", NORM, NORM);

    // asynchronous reset in the middle of MD_BUSY
    s = idle; s.ex_md_start = 1'b1;
    step(s, "rst_md_issue", MD, MD);
    step(idle, "rst_md_busy", MD, MD);
    #2;
    s = idle; s.rst_n = 1'b0;
    drive(s);
    m_s1 = 0; m_f1 = 0; m_s2 = 0; m_f2 = 0;
    push_exp("rst_async", RST, RST);
    #1;
    pop_check();
    step(idle, "rst_release", NORM, NORM);
    step(idle, "rst_after", NORM, NORM);

    // 2^4+3 stall cycles saturate the 4-bit counter
    s = idle; s.mem_req = 1'b1; s.dmem_ready = 1'b0;
    for (int i = 0; i < 19; i++) step(s, "sat_stall", MEMW, MEMW);
    step(idle, "sat_hold", NORM, NORM);
    s = idle; s.cnt_clr = 1'b1; s.mem_req = 1'b1; s.dmem_ready = 1'b0;
    step(s, "clr_vs_inc", MEMW, MEMW);
    step(idle, "clr_after", NORM, NORM);
    step(idle, "final", NORM, NORM);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the RV32I core, sitting beside the IF/ID/EX/MEM/WB pipeline registers. It replaces single-cycle load-use detection with:
- configurable load latency and `x0`/operand-use qualification;
- a start/done handshake for a multi-cycle MUL/DIV unit in EX;
- data-memory wait-state freezing;
- branch flush arbitration;
- saturating stall and flush performance counters.

## Interface
Parameters:
- `RA_W`, 5, register-address width.
- `LOAD_LAT`, 1, load-use distance in cycles: 1 checks EX only, 2 checks EX and MEM.
- `CNT_W`, 16, performance-counter width.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  RA_W  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1  operand actually read by the ID instruction.
- `ex_rd`  in  RA_W  destination register of the EX instruction.
- `ex_mem_read`  in  1  EX instruction is a load.
- `mem_rd`  in  RA_W  destination register of the MEM instruction.
- `mem_mem_read`  in  1  MEM instruction is a load; used only when LOAD_LAT=2.
- `ex_md_start`  in  1  MUL/DIV issue pulse from EX.
- `md_done`  in  1  MUL/DIV result valid pulse.
- `mem_req`  in  1  MEM instruction accesses data memory.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `branch_taken`  in  1  redirect resolved in EX.
- `cnt_clr`  in  1  synchronous counter clear.
- `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write`  out  1  pipeline-register enables.
- `id_ex_bubble`, `ex_mem_bubble`, `mem_wb_bubble`  out  1  insert NOP into the named register.
- `if_id_flush`, `id_ex_flush`  out  1  squash wrong-path instructions.
- `stall`  out  1  any stall or freeze active.
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating performance counters.

## Operation
- FSM in `hazard_pkg::hz_state_e` has two states, RUN and MD_BUSY.
  - RUN → MD_BUSY when `ex_md_start=1`, `md_done=0` and there is no freeze.
  - MD_BUSY → RUN when `md_done=1`.
  - `ex_md_start` together with `md_done` in the same cycle stays in RUN and causes no stall.
- Hazard conditions:
  - **load_use**: (`ex_mem_read`, `ex_rd≠0`, and a used `id_rs` equals `ex_rd`), OR, when LOAD_LAT=2, the same test against `mem_mem_read`/`mem_rd`.
  - **md_wait**: (RUN and `ex_md_start` and !`md_done`) or (MD_BUSY and !`md_done`).
  - **mem_wait**: `mem_req` and !`dmem_ready`.
- Priority is mem_wait > md_wait > branch > load_use. Only the highest active cause acts.
- Default outputs: all write enables = 1; all bubbles and flushes = 0.
- mem_wait (freeze):
  - all four enables = 0 and `mem_wb_bubble` = 1.
  - Flushes are suppressed. `branch_taken` stays held in EX and is re-evaluated after the freeze.
- md_wait:
  - `pc_write`, `if_id_write`, `id_ex_write` = 0; `ex_mem_bubble` = 1.
- branch:
  - `if_id_flush` and `id_ex_flush` = 1.
  - A coincident load_use is dropped, because its consumer is on the squashed path.
- load_use:
  - `pc_write` and `if_id_write` = 0; `id_ex_bubble` = 1.
- `stall` = 1 whenever mem_wait, md_wait or an applied load_use is active.
- Counters:
  - `stall_cnt` increments on each cycle with `stall=1`.
  - `flush_cnt` increments on each cycle in which a flush is applied.
  - Both saturate at 2^CNT_W−1.
  - `cnt_clr` zeroes both, with priority over increment.

## Timing
- All hazard outputs are combinational from the current inputs and the registered state. Only the state and the counters are registered.
- Load-use stall lasts exactly LOAD_LAT cycles for a back-to-back load→consumer pair.
  - For LOAD_LAT=2 with one independent instruction between load and consumer: 1 cycle.
- A MUL/DIV stall covers the issue cycle through the cycle before `md_done`. `md_done` releases the stall in the same cycle.
- mem_wait during MD_BUSY:
  - The FSM holds state.
  - A `md_done` that arrives while frozen still returns the FSM to RUN, and the stall ends once the freeze drops.
- Reset:
  - `rst_n` low immediately forces state RUN and counters 0.
  - While reset is asserted, all enables = 0, and bubbles, flushes and `stall` = 0.
  - This applies equally mid-stall: there is no residual stall after release.
  - The first edge after deassertion runs normally.

## Structure
- `hazard_pkg` holds:
  - `hz_state_e`;
  - `hz_cause_e` (NONE, LOAD_USE, BRANCH, MD_WAIT, MEM_WAIT);
  - the register-address width constant shared with the decode stage.
- Sub-module `sat_counter` (parameter W; inputs `clk`, `rst_n`, `clr`, `inc`; output `q`) is instantiated twice, for the two counters.
- Cause selection is a single priority-encoded `always_comb`. The FSM and counters use `always_ff` on `posedge clk or negedge rst_n`.

## Test plan
- **Load-use**, LOAD_LAT=1: EX load `ex_rd=5`, ID `id_rs2=5` used.
  - Expect 1 cycle with `pc_write=0`, `id_ex_bubble=1`, `stall_cnt` +1.
  - Repeat with `ex_rd=0`, and with the operand unused: no stall.
- **Load-use**, LOAD_LAT=2: load then consumer back-to-back → 2 stall cycles. With one independent instruction between them → 1 stall cycle.
- **MUL/DIV**: `ex_md_start` pulse, `md_done` 4 cycles later.
  - Expect a 4-cycle stall with `ex_mem_bubble=1` and state returning to RUN.
  - Start and done in the same cycle → 0 stall cycles.
- **Memory freeze**: `mem_req=1`, `dmem_ready=0` for 3 cycles with `branch_taken=1`.
  - Expect all enables 0 and no flush for those 3 cycles.
  - The flush is applied in the cycle `dmem_ready` rises; `flush_cnt`=1.
- **Branch vs load-use** (LOAD_LAT=2): MEM load hazard and `branch_taken` together → flushes=1, `stall`=0.
- **Reset and counters**:
  - `rst_n` pulsed low mid-MD_BUSY → state RUN and counters 0 asynchronously.
  - Force 2^CNT_W+3 stall cycles → `stall_cnt` holds all-ones.
  - `cnt_clr` → 0.
